// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared encodings and types for the sequenced counter controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnt_seq_ctrl_pkg;

  // Width of the terminal-count datapath.
  localparam int CNT_W = 4;

  // FSM state encoding, visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_START  = 2'b00,
    OP_STOP   = 2'b01,
    OP_RESUME = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  // Run configuration latched by START.
  // The prescale divisor is kept separately because its width is a parameter.
  typedef struct packed {
    logic [CNT_W-1:0] limit;
    logic             reload;
  } cfg_t;

  // True when the counter sits on its terminal value.
  function automatic logic is_terminal(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lim);
    return (cnt == lim);
  endfunction

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Command channel of the sequenced counter: valid/ready handshake plus payload.
// Latency: n/a (wiring only).
// Backpressure: slave deasserts cmd_ready; master holds its payload until accepted.
interface cnt_seq_ctrl_if #(
  parameter int PRESCALE_W = 8
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [3:0]            cmd_limit;
  logic                  cmd_reload;
  logic [PRESCALE_W-1:0] cmd_div;

  // Command source side.
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_limit,
    output cmd_reload,
    output cmd_div,
    input  cmd_ready
  );

  // Command sink side (the controller).
  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_limit,
    input  cmd_reload,
    input  cmd_div,
    output cmd_ready
  );

endinterface

// File: rtl/cnt_seq_ctrl_cnt4_core.sv
// 4-bit counter datapath with synchronous clear and increment enable.
// Latency: out reflects clr/inc one clock after the edge that samples them.
// Backpressure: none; clr takes priority over inc.
module cnt4_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] out
);

  // Counter register: clear wins over increment, 4-bit wrap is natural.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (clr) begin
      out <= '0;
    end else if (inc) begin
      out <= out + 4'd1;
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command-driven prescaled counter with run/pause/done sequencing.
// Latency: count/state/busy/done_pulse update one clock after an accepted command or tick.
// Backpressure: cmd_ready drops for the single cycle following each acceptance.
module cnt_seq_ctrl
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  cnt_seq_ctrl_if.slave       cmd,
  output logic [CNT_W-1:0]    count,
  output logic [1:0]          state,
  output logic                busy,
  output logic                done_pulse
);

  // Registered state.
  state_e                state_q;
  logic [PRESCALE_W-1:0] psc_q;
  logic [PRESCALE_W-1:0] div_q;
  cfg_t                  cfg_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;

  // Next-state values.
  state_e                state_d;
  logic [PRESCALE_W-1:0] psc_d;
  logic [PRESCALE_W-1:0] div_d;
  cfg_t                  cfg_d;
  logic                  done_d;

  // Datapath controls for the counter core.
  logic cnt_clr;
  logic cnt_inc;

  // Handshake and tick qualifiers.
  op_e  op;
  logic accept;
  logic psc_hit;

  assign op      = op_e'(cmd.cmd_op);
  assign accept  = cmd.cmd_valid & ready_q;
  assign psc_hit = (psc_q == div_q);

  cnt4_core u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .out   (count)
  );

  // Next-state, prescaler and counter control.
  // An accepted command owns the edge: any tick that would have landed on it
  // is dropped, and the prescaler only moves if the command resets it.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    div_d   = div_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    if (accept) begin
      case (op)
        OP_START: begin
          cfg_d.limit  = cmd.cmd_limit;
          cfg_d.reload = cmd.cmd_reload;
          div_d        = cmd.cmd_div;
          psc_d        = '0;
          cnt_clr      = 1'b1;
          state_d      = ST_RUN;
        end
        OP_STOP: begin
          if (state_q == ST_RUN) begin
            state_d = ST_PAUSE;
          end
        end
        OP_RESUME: begin
          if (state_q == ST_PAUSE) begin
            state_d = ST_RUN;
          end
        end
        OP_CLEAR: begin
          psc_d   = '0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (state_q == ST_RUN) begin
      psc_d = psc_hit ? '0 : psc_q + 1'b1;
      if (psc_hit) begin
        if (is_terminal(count, cfg_q.limit)) begin
          done_d = 1'b1;
          // One-shot parks on the limit value; auto-reload starts over.
          if (cfg_q.reload) begin
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
    end
  end

  // State, configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      psc_q   <= '0;
      div_q   <= '0;
      cfg_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      div_q   <= div_d;
      cfg_q   <= cfg_d;
      ready_q <= ~accept;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= done_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign state         = state_q;
  assign busy          = busy_q;
  assign done_pulse    = done_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: a per-cycle vector table plus hand sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: vectors drive cmd_valid regardless of cmd_ready to exercise the stall cycle.
module tb_cnt_seq_ctrl;
  import cnt_seq_ctrl_pkg::*;

  localparam int PW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] count;
  logic [1:0] state;
  logic       busy;
  logic       done_pulse;

  cnt_seq_ctrl_if #(.PRESCALE_W(PW)) cif ();

  cnt_seq_ctrl #(.PRESCALE_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cif),
    .count      (count),
    .state      (state),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int v; int op; int lim; int rel; int div;
    int e_cnt; int e_st; int e_busy; int e_done; int e_rdy;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int s, input int b,
                         input int d, input int r);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".state"}, int'(state), s);
    chk({tag, ".busy"},  int'(busy), b);
    chk({tag, ".done"},  int'(done_pulse), d);
    chk({tag, ".ready"}, int'(cif.cmd_ready), r);
  endtask

  // Present one command (or none) for a single clock, then sample after the edge.
  task automatic step(input int v, input int op, input int lim, input int rel, input int div);
    cif.cmd_valid  = 1'(v);
    cif.cmd_op     = 2'(op);
    cif.cmd_limit  = 4'(lim);
    cif.cmd_reload = 1'(rel);
    cif.cmd_div    = PW'(div);
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    //            v  op         lim rel div  cnt st        busy done rdy
    vt[0]  = '{1, OP_START,  3, 0, 0,   0, ST_RUN,   1, 0, 0};
    vt[1]  = '{0, OP_START,  0, 0, 0,   1, ST_RUN,   1, 0, 1};
    vt[2]  = '{0, OP_START,  0, 0, 0,   2, ST_RUN,   1, 0, 1};
    vt[3]  = '{0, OP_START,  0, 0, 0,   3, ST_RUN,   1, 0, 1};
    vt[4]  = '{0, OP_START,  0, 0, 0,   3, ST_DONE,  0, 1, 1};
    vt[5]  = '{0, OP_START,  0, 0, 0,   3, ST_DONE,  0, 0, 1};
    vt[6]  = '{1, OP_STOP,   0, 0, 0,   3, ST_DONE,  0, 0, 0};
    vt[7]  = '{1, OP_CLEAR,  0, 0, 0,   3, ST_DONE,  0, 0, 1};
    vt[8]  = '{1, OP_CLEAR,  0, 0, 0,   0, ST_IDLE,  0, 0, 0};
    vt[9]  = '{0, OP_START,  0, 0, 0,   0, ST_IDLE,  0, 0, 1};
    vt[10] = '{1, OP_START,  0, 1, 0,   0, ST_RUN,   1, 0, 0};
    vt[11] = '{0, OP_START,  0, 0, 0,   0, ST_RUN,   1, 1, 1};
    vt[12] = '{0, OP_START,  0, 0, 0,   0, ST_RUN,   1, 1, 1};
    vt[13] = '{1, OP_START,  1, 0, 1,   0, ST_RUN,   1, 0, 0};
    vt[14] = '{0, OP_START,  0, 0, 0,   0, ST_RUN,   1, 0, 1};
    vt[15] = '{0, OP_START,  0, 0, 0,   1, ST_RUN,   1, 0, 1};
    vt[16] = '{0, OP_START,  0, 0, 0,   1, ST_RUN,   1, 0, 1};
    vt[17] = '{0, OP_START,  0, 0, 0,   1, ST_DONE,  0, 1, 1};
    vt[18] = '{1, OP_CLEAR,  0, 0, 0,   0, ST_IDLE,  0, 0, 0};
    vt[19] = '{0, OP_START,  0, 0, 0,   0, ST_IDLE,  0, 0, 1};
    vt[20] = '{1, OP_STOP,   0, 0, 0,   0, ST_IDLE,  0, 0, 0};
    vt[21] = '{1, OP_RESUME, 0, 0, 0,   0, ST_IDLE,  0, 0, 1};
    vt[22] = '{1, OP_RESUME, 0, 0, 0,   0, ST_IDLE,  0, 0, 0};
    vt[23] = '{0, OP_START,  0, 0, 0,   0, ST_IDLE,  0, 0, 1};

    rst_n          = 1'b0;
    cif.cmd_valid  = 1'b0;
    cif.cmd_op     = 2'b00;
    cif.cmd_limit  = 4'd0;
    cif.cmd_reload = 1'b0;
    cif.cmd_div    = '0;

    // Reset state.
    #12;
    chk_all("reset", 0, ST_IDLE, 0, 0, 1);
    rst_n = 1'b1;

    // Per-cycle vector table: one-shot run, back-to-back commands, limit 0, tick collision.
    for (int i = 0; i < 24; i++) begin
      step(vt[i].v, vt[i].op, vt[i].lim, vt[i].rel, vt[i].div);
      chk_all($sformatf("v%0d", i), vt[i].e_cnt, vt[i].e_st, vt[i].e_busy,
              vt[i].e_done, vt[i].e_rdy);
    end

    // Auto-reload, limit 2, divide by 3: count steps every 3 clocks, done every 9.
    step(1, OP_START, 2, 1, 2);
    chk("rl.start.count", int'(count), 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("rl%0d.count", k), int'(count), (k / 3) % 3);
      chk($sformatf("rl%0d.done", k), int'(done_pulse), (k % 9 == 0) ? 1 : 0);
      chk($sformatf("rl%0d.busy", k), int'(busy), 1);
    end
    step(1, OP_CLEAR, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Pause and resume, limit 15, no prescale.
    step(1, OP_START, 15, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("pr%0d.count", k), int'(count), k);
    end
    step(1, OP_STOP, 0, 0, 0);
    chk_all("pr.stop", 5, ST_PAUSE, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("pr.hold%0d.count", k), int'(count), 5);
      chk($sformatf("pr.hold%0d.state", k), int'(state), ST_PAUSE);
    end
    step(1, OP_RESUME, 0, 0, 0);
    chk_all("pr.resume", 5, ST_RUN, 1, 0, 0);
    for (int j = 1; j <= 10; j++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("pr.run%0d.count", j), int'(count), 5 + j);
      chk($sformatf("pr.run%0d.done", j), int'(done_pulse), 0);
    end
    step(0, 0, 0, 0, 0);
    chk_all("pr.term", 15, ST_DONE, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    chk_all("pr.after", 15, ST_DONE, 0, 0, 1);

    // CLEAR lands on the terminal tick edge: tick discarded, no done_pulse.
    step(1, OP_START, 4, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("ct%0d.count", k), int'(count), k);
    end
    step(1, OP_CLEAR, 0, 0, 0);
    chk_all("ct.clear", 0, ST_IDLE, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_all("ct.after", 0, ST_IDLE, 0, 0, 1);

    // Asynchronous reset mid-run at count 7.
    step(1, OP_START, 15, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 0, 0, 0);
    end
    chk("ar.pre.count", int'(count), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("ar.async", 0, ST_IDLE, 0, 0, 1);
    @(posedge clk);
    #1;
    chk_all("ar.held", 0, ST_IDLE, 0, 0, 1);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0);
      chk_all($sformatf("ar.idle%0d", k), 0, ST_IDLE, 0, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
